// File: rtl/pong_pkg.sv
// pong_pkg: shared definitions for the Pong top-level sequencer.
//   - state_e    : sequencer state encoding (MENU..PAUSE)
//   - RGB_W      : colour width of both video pipelines
//   - COORD_W    : width of mouse coordinates
//   - WINNER_*   : match result codes
//   - in_rect()  : half-open rectangle hit test on 13-bit sums
package pong_pkg;

   localparam int RGB_W   = 12;
   localparam int COORD_W = 12;

   typedef enum logic [2:0] {
      ST_MENU      = 3'd0,
      ST_ARMED     = 3'd1,
      ST_COUNTDOWN = 3'd2,
      ST_PLAY      = 3'd3,
      ST_OVER      = 3'd4,
      ST_PAUSE     = 3'd5
   } state_e;

   localparam logic [1:0] WINNER_NONE  = 2'b00;
   localparam logic [1:0] WINNER_LEFT  = 2'b01;
   localparam logic [1:0] WINNER_RIGHT = 2'b10;
   localparam logic [1:0] WINNER_DRAW  = 2'b11;

   // Point (px,py) lies in [x0, x0+w) x [y0, y0+h); 13-bit sums cannot wrap.
   function automatic logic in_rect(input logic [12:0] px, input logic [12:0] py,
                                    input logic [12:0] x0, input logic [12:0] y0,
                                    input logic [12:0] w,  input logic [12:0] h);
      logic [12:0] x1;
      logic [12:0] y1;
      x1 = x0 + w;
      y1 = y0 + h;
      return (px >= x0) && (px < x1) && (py >= y0) && (py < y1);
   endfunction

endpackage

// File: rtl/edge_detect.sv
// edge_detect: registers a level and produces registered one-cycle pulses
// on its 0->1 (rise) and 1->0 (fall) transitions.
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset
//   din  in  level to watch
//   rise out one-cycle pulse after a 0->1 transition
//   fall out one-cycle pulse after a 1->0 transition
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic din_r;
   logic rise_r;
   logic fall_r;

   // Delay the level one cycle and register the transition pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         din_r  <= 1'b0;
         rise_r <= 1'b0;
         fall_r <= 1'b0;
      end else begin
         din_r  <= din;
         rise_r <= din & ~din_r;
         fall_r <= ~din & din_r;
      end
   end

   assign rise = rise_r;
   assign fall = fall_r;

endmodule

// File: rtl/game_state_ctl.sv
// game_state_ctl: top-level Pong sequencer. Chooses the menu or game video
// pipeline for the VGA output, starts a match on a START button click, runs a
// frame-counted countdown, keeps score, and returns to the menu after the
// result has been shown.
// Optional feature macro: GAME_PAUSE_EN (click START in PLAY to pause/resume).
// Ports:
//   pclk, rst                      pixel clock, synchronous active-high reset
//   xpos, ypos, mouse_left         mouse position and left button level
//   vsync_in                       frame boundary on its rising edge
//   score_l_pulse, score_r_pulse   one-cycle scoring pulses
//   menu_* / game_*                syncs and colour of the two pipelines
//   hsync_out, vsync_out, rgb_out  selected video, one cycle late
//   game_rst, game_run             ball/paddle reset and motion enable
//   state_out                      current state encoding
//   score_l, score_r, winner       scores and match result
//   countdown_out                  frames remaining in COUNTDOWN, else 0
module game_state_ctl
   import pong_pkg::*;
#(
   parameter int BTN_X0           = 352,
   parameter int BTN_Y0           = 280,
   parameter int BTN_W            = 128,
   parameter int BTN_H            = 32,
   parameter int COUNTDOWN_FRAMES = 180,
   parameter int WIN_SCORE        = 5,
   parameter int OVER_FRAMES      = 240
) (
   input  logic               pclk,
   input  logic               rst,
   input  logic [COORD_W-1:0] xpos,
   input  logic [COORD_W-1:0] ypos,
   input  logic               mouse_left,
   input  logic               vsync_in,
   input  logic               score_l_pulse,
   input  logic               score_r_pulse,
   input  logic               menu_hsync,
   input  logic               menu_vsync,
   input  logic [RGB_W-1:0]   menu_rgb,
   input  logic               game_hsync,
   input  logic               game_vsync,
   input  logic [RGB_W-1:0]   game_rgb,
   output logic               hsync_out,
   output logic               vsync_out,
   output logic [RGB_W-1:0]   rgb_out,
   output logic               game_rst,
   output logic               game_run,
   output logic [2:0]         state_out,
   output logic [3:0]         score_l,
   output logic [3:0]         score_r,
   output logic [1:0]         winner,
   output logic [7:0]         countdown_out
);

   localparam logic [7:0] CD_LOAD   = 8'(COUNTDOWN_FRAMES);
   localparam logic [7:0] OVER_LOAD = 8'(OVER_FRAMES);
   localparam logic [3:0] WIN_VAL   = 4'(WIN_SCORE);

   logic frame_tick_s;
   logic press_s;
   logic release_s;
   logic in_btn_s;
   logic pause_req_s;
   logic target_game_s;

   state_e     state_r;
   state_e     state_nxt_s;
   logic [7:0] cnt_r;
   logic [7:0] cnt_nxt_s;
   logic [3:0] score_l_r;
   logic [3:0] score_r_r;
   logic [3:0] score_l_nxt_s;
   logic [3:0] score_r_nxt_s;
   logic [3:0] score_l_sum_s;
   logic [3:0] score_r_sum_s;
   logic [1:0] winner_r;
   logic [1:0] winner_nxt_s;
   logic       src_sel_r;
   logic       hsync_r;
   logic       vsync_r;
   logic [RGB_W-1:0] rgb_r;
   logic       game_rst_r;
   logic       game_run_r;
   logic [7:0] countdown_r;
   logic       vsync_fall_unused_s;
   logic       mouse_rise_s;

   edge_detect u_vsync_edge (
      .clk  (pclk),
      .rst  (rst),
      .din  (vsync_in),
      .rise (frame_tick_s),
      .fall (vsync_fall_unused_s)
   );

   edge_detect u_mouse_edge (
      .clk  (pclk),
      .rst  (rst),
      .din  (mouse_left),
      .rise (mouse_rise_s),
      .fall (release_s)
   );

   assign press_s  = mouse_rise_s;
   assign in_btn_s = in_rect({1'b0, xpos}, {1'b0, ypos},
                             13'(BTN_X0), 13'(BTN_Y0), 13'(BTN_W), 13'(BTN_H));

`ifdef GAME_PAUSE_EN
   assign pause_req_s = press_s & in_btn_s;
`else
   assign pause_req_s = 1'b0;
`endif

   // Saturating increments; only committed while in PLAY.
   assign score_l_sum_s = score_l_r + {3'b000, (score_l_pulse && (score_l_r != WIN_VAL))};
   assign score_r_sum_s = score_r_r + {3'b000, (score_r_pulse && (score_r_r != WIN_VAL))};

   // Game video is shown whenever a match is in progress or its result is up.
   assign target_game_s = (state_r == ST_COUNTDOWN) || (state_r == ST_PLAY) ||
                          (state_r == ST_OVER)      || (state_r == ST_PAUSE);

   // Next-state, frame counter, score and winner logic.
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      score_l_nxt_s = score_l_r;
      score_r_nxt_s = score_r_r;
      winner_nxt_s  = winner_r;
      case (state_r)
         ST_MENU: begin
            if (press_s && in_btn_s) begin
               state_nxt_s = ST_ARMED;
            end else begin
               state_nxt_s = ST_MENU;
            end
         end
         ST_ARMED: begin
            if (release_s) begin
               if (in_btn_s) begin
                  state_nxt_s   = ST_COUNTDOWN;
                  cnt_nxt_s     = CD_LOAD;
                  score_l_nxt_s = 4'd0;
                  score_r_nxt_s = 4'd0;
                  winner_nxt_s  = WINNER_NONE;
               end else begin
                  state_nxt_s = ST_MENU;
               end
            end else begin
               state_nxt_s = ST_ARMED;
            end
         end
         ST_COUNTDOWN: begin
            if (frame_tick_s) begin
               if (cnt_r <= 8'd1) begin
                  state_nxt_s = ST_PLAY;
                  cnt_nxt_s   = 8'd0;
               end else begin
                  cnt_nxt_s = cnt_r - 8'd1;
               end
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         ST_PLAY: begin
            if (pause_req_s) begin
               state_nxt_s = ST_PAUSE;
            end else begin
               score_l_nxt_s = score_l_sum_s;
               score_r_nxt_s = score_r_sum_s;
               if ((score_l_sum_s == WIN_VAL) || (score_r_sum_s == WIN_VAL)) begin
                  state_nxt_s = ST_OVER;
                  cnt_nxt_s   = OVER_LOAD;
                  if ((score_l_sum_s == WIN_VAL) && (score_r_sum_s == WIN_VAL)) begin
                     winner_nxt_s = WINNER_DRAW;
                  end else if (score_l_sum_s == WIN_VAL) begin
                     winner_nxt_s = WINNER_LEFT;
                  end else begin
                     winner_nxt_s = WINNER_RIGHT;
                  end
               end else begin
                  state_nxt_s = ST_PLAY;
               end
            end
         end
         ST_OVER: begin
            if (frame_tick_s) begin
               if (cnt_r <= 8'd1) begin
                  state_nxt_s = ST_MENU;
                  cnt_nxt_s   = 8'd0;
               end else begin
                  cnt_nxt_s = cnt_r - 8'd1;
               end
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
`ifdef GAME_PAUSE_EN
         ST_PAUSE: begin
            if (pause_req_s) begin
               state_nxt_s = ST_PLAY;
            end else begin
               state_nxt_s = ST_PAUSE;
            end
         end
`endif
         default: begin
            state_nxt_s = ST_MENU;
            cnt_nxt_s   = 8'd0;
         end
      endcase
   end

   // State, counters, scores, source select and registered outputs.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_r     <= ST_MENU;
         cnt_r       <= 8'd0;
         score_l_r   <= 4'd0;
         score_r_r   <= 4'd0;
         winner_r    <= WINNER_NONE;
         src_sel_r   <= 1'b0;
         hsync_r     <= 1'b0;
         vsync_r     <= 1'b0;
         rgb_r       <= '0;
         game_rst_r  <= 1'b1;
         game_run_r  <= 1'b0;
         countdown_r <= 8'd0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         score_l_r   <= score_l_nxt_s;
         score_r_r   <= score_r_nxt_s;
         winner_r    <= winner_nxt_s;
         // Source only changes at a frame boundary so no frame is torn.
         if (frame_tick_s) begin
            src_sel_r <= target_game_s;
         end else begin
            src_sel_r <= src_sel_r;
         end
         hsync_r     <= src_sel_r ? game_hsync : menu_hsync;
         vsync_r     <= src_sel_r ? game_vsync : menu_vsync;
         rgb_r       <= src_sel_r ? game_rgb   : menu_rgb;
         game_rst_r  <= (state_nxt_s == ST_MENU) || (state_nxt_s == ST_ARMED);
         game_run_r  <= (state_nxt_s == ST_PLAY);
         countdown_r <= (state_nxt_s == ST_COUNTDOWN) ? cnt_nxt_s : 8'd0;
      end
   end

   assign hsync_out     = hsync_r;
   assign vsync_out     = vsync_r;
   assign rgb_out       = rgb_r;
   assign game_rst      = game_rst_r;
   assign game_run      = game_run_r;
   assign state_out     = state_r;
   assign score_l       = score_l_r;
   assign score_r       = score_r_r;
   assign winner        = winner_r;
   assign countdown_out = countdown_r;

endmodule

// File: tb/tb_game_state_ctl.sv
// tb_game_state_ctl: directed bench for game_state_ctl. Expected values are
// pushed into a queue alongside the stimulus and popped/compared once the
// DUT has had the cycles it needs to respond.
module tb_game_state_ctl;
   import pong_pkg::*;

   localparam logic [11:0] MENU_C = 12'h0A5;
   localparam logic [11:0] GAME_C = 12'h5A0;

   logic        pclk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] xpos = 12'd0;
   logic [11:0] ypos = 12'd0;
   logic        mouse_left = 1'b0;
   logic        vsync_in = 1'b0;
   logic        score_l_pulse = 1'b0;
   logic        score_r_pulse = 1'b0;
   logic        menu_hsync = 1'b1;
   logic        menu_vsync = 1'b0;
   logic [11:0] menu_rgb = MENU_C;
   logic        game_hsync = 1'b0;
   logic        game_vsync = 1'b1;
   logic [11:0] game_rgb = GAME_C;
   logic        hsync_out;
   logic        vsync_out;
   logic [11:0] rgb_out;
   logic        game_rst;
   logic        game_run;
   logic [2:0]  state_out;
   logic [3:0]  score_l;
   logic [3:0]  score_r;
   logic [1:0]  winner;
   logic [7:0]  countdown_out;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t exp_q[$];

   game_state_ctl dut (
      .pclk          (pclk),
      .rst           (rst),
      .xpos          (xpos),
      .ypos          (ypos),
      .mouse_left    (mouse_left),
      .vsync_in      (vsync_in),
      .score_l_pulse (score_l_pulse),
      .score_r_pulse (score_r_pulse),
      .menu_hsync    (menu_hsync),
      .menu_vsync    (menu_vsync),
      .menu_rgb      (menu_rgb),
      .game_hsync    (game_hsync),
      .game_vsync    (game_vsync),
      .game_rgb      (game_rgb),
      .hsync_out     (hsync_out),
      .vsync_out     (vsync_out),
      .rgb_out       (rgb_out),
      .game_rst      (game_rst),
      .game_run      (game_run),
      .state_out     (state_out),
      .score_l       (score_l),
      .score_r       (score_r),
      .winner        (winner),
      .countdown_out (countdown_out)
   );

   always #5 pclk = ~pclk;

   function automatic logic [31:0] obs(input int sel);
      case (sel)
         0:       return {29'd0, state_out};
         1:       return {28'd0, score_l};
         2:       return {28'd0, score_r};
         3:       return {30'd0, winner};
         4:       return {24'd0, countdown_out};
         5:       return {31'd0, game_rst};
         6:       return {31'd0, game_run};
         7:       return {20'd0, rgb_out};
         8:       return {31'd0, hsync_out};
         9:       return {31'd0, vsync_out};
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = v;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] o;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs(e.sel);
         tests++;
         assert (o === e.exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.exp);
         end
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic press(input logic [11:0] x, input logic [11:0] y);
      xpos = x;
      ypos = y;
      mouse_left = 1'b1;
      step();
      step();
   endtask

   task automatic release_at(input logic [11:0] x, input logic [11:0] y);
      xpos = x;
      ypos = y;
      mouse_left = 1'b0;
      step();
      step();
   endtask

   task automatic vsync_pulse();
      vsync_in = 1'b1;
      step();
      vsync_in = 1'b0;
      step();
   endtask

   task automatic pulse(input logic l, input logic r);
      score_l_pulse = l;
      score_r_pulse = r;
      step();
      score_l_pulse = 1'b0;
      score_r_pulse = 1'b0;
   endtask

   task automatic start_match();
      press(12'd400, 12'd290);
      release_at(12'd400, 12'd295);
      repeat (180) vsync_pulse();
   endtask

   initial begin
      // Reset values.
      rst = 1'b1;
      step();
      step();
      push("rst_state", 0, 32'd0);
      push("rst_score_l", 1, 32'd0);
      push("rst_score_r", 2, 32'd0);
      push("rst_winner", 3, 32'd0);
      push("rst_countdown", 4, 32'd0);
      push("rst_game_rst", 5, 32'd1);
      push("rst_game_run", 6, 32'd0);
      push("rst_rgb", 7, 32'd0);
      push("rst_hsync", 8, 32'd0);
      drain();
      rst = 1'b0;
      step();
      push("menu_rgb_sel", 7, {20'd0, MENU_C});
      push("menu_hsync_sel", 8, 32'd1);
      drain();

      // Right edge x=480 is outside the button.
      press(12'd480, 12'd290);
      push("edge_x480_no_armed", 0, 32'd0);
      drain();
      release_at(12'd480, 12'd290);

      // Top-left corner is inside; release outside returns to MENU.
      press(12'd352, 12'd280);
      push("corner_armed", 0, 32'd1);
      push("armed_game_rst", 5, 32'd1);
      drain();
      release_at(12'd10, 12'd10);
      push("release_out_menu", 0, 32'd0);
      push("release_out_scores", 1, 32'd0);
      drain();

      // Normal start and countdown.
      press(12'd400, 12'd290);
      push("press_armed", 0, 32'd1);
      drain();
      release_at(12'd400, 12'd295);
      push("cd_state", 0, 32'd2);
      push("cd_load", 4, 32'd180);
      push("cd_game_rst", 5, 32'd0);
      push("cd_game_run", 6, 32'd0);
      push("cd_rgb_still_menu", 7, {20'd0, MENU_C});
      drain();
      vsync_pulse();
      push("cd_first_tick", 4, 32'd179);
      drain();
      step();
      push("src_game_after_tick", 7, {20'd0, GAME_C});
      push("vsync_game_after_tick", 9, 32'd1);
      drain();
      repeat (178) vsync_pulse();
      push("cd_last_state", 0, 32'd2);
      push("cd_last_count", 4, 32'd1);
      drain();
      vsync_pulse();
      push("play_state", 0, 32'd3);
      push("play_count_zero", 4, 32'd0);
      push("play_game_run", 6, 32'd1);
      push("play_game_rst", 5, 32'd0);
      drain();

      // Reset mid-PLAY at 3:1.
      repeat (3) pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      push("mid_score_l", 1, 32'd3);
      push("mid_score_r", 2, 32'd1);
      drain();
      rst = 1'b1;
      step();
      push("midrst_state", 0, 32'd0);
      push("midrst_score_l", 1, 32'd0);
      push("midrst_score_r", 2, 32'd0);
      push("midrst_game_rst", 5, 32'd1);
      push("midrst_rgb", 7, 32'd0);
      drain();
      rst = 1'b0;
      step();

      // Right player wins 0:5.
      start_match();
      repeat (4) pulse(1'b0, 1'b1);
      push("r4_state", 0, 32'd3);
      push("r4_score", 2, 32'd4);
      drain();
      pulse(1'b0, 1'b1);
      push("r5_state_over", 0, 32'd4);
      push("r5_score", 2, 32'd5);
      push("r5_winner", 3, 32'd2);
      push("over_game_run", 6, 32'd0);
      push("over_game_rst", 5, 32'd0);
      drain();
      pulse(1'b1, 1'b0);
      press(12'd400, 12'd290);
      release_at(12'd400, 12'd290);
      push("over_pulse_ignored", 1, 32'd0);
      push("over_click_ignored", 0, 32'd4);
      drain();
      repeat (239) vsync_pulse();
      push("over_239", 0, 32'd4);
      drain();
      vsync_pulse();
      push("over_to_menu", 0, 32'd0);
      push("menu_game_rst", 5, 32'd1);
      drain();
      step();
      push("menu_rgb_held_game", 7, {20'd0, GAME_C});
      drain();
      vsync_pulse();
      step();
      push("menu_rgb_back", 7, {20'd0, MENU_C});
      drain();
      menu_rgb = 12'h123;
      step();
      push("menu_rgb_latency", 7, 32'h123);
      drain();

      // Simultaneous win at 4:4.
      start_match();
      repeat (4) pulse(1'b1, 1'b1);
      push("draw_pre_l", 1, 32'd4);
      push("draw_pre_state", 0, 32'd3);
      drain();
      pulse(1'b1, 1'b1);
      push("draw_score_l", 1, 32'd5);
      push("draw_score_r", 2, 32'd5);
      push("draw_winner", 3, 32'd3);
      push("draw_state", 0, 32'd4);
      drain();
      pulse(1'b1, 1'b0);
      push("draw_after_pulse_l", 1, 32'd5);
      drain();

`ifdef GAME_PAUSE_EN
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      start_match();
      press(12'd400, 12'd290);
      push("pause_state", 0, 32'd5);
      push("pause_game_run", 6, 32'd0);
      drain();
      pulse(1'b1, 1'b0);
      release_at(12'd400, 12'd290);
      push("pause_score_held", 1, 32'd0);
      drain();
      press(12'd400, 12'd290);
      push("resume_state", 0, 32'd3);
      push("resume_game_run", 6, 32'd1);
      drain();
      release_at(12'd400, 12'd290);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/game_state_ctl.md
Name: game_state_ctl

Overview:
- Top-level sequencer for the Pong game.
- Decides whether the menu video pipeline or the game video pipeline drives the VGA output.
- Starts a match when the on-screen START button is clicked, then runs a frame-counted countdown.
- Tracks scores and ends the match at a win score, then returns to the menu after a hold time.
- Sits after the menu and game rendering chains, immediately before the VGA output registers.

Parameters:
- BTN_X0, 352, START button left edge (pixels)
- BTN_Y0, 280, START button top edge (pixels)
- BTN_W, 128, START button width
- BTN_H, 32, START button height
- COUNTDOWN_FRAMES, 180, frames from click-release to PLAY (1..255)
- WIN_SCORE, 5, points that end a match (1..15)
- OVER_FRAMES, 240, frames the result is shown before MENU (1..255)

Ports:
- pclk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- xpos  in  12  mouse x, already synchronous to pclk
- ypos  in  12  mouse y, already synchronous to pclk
- mouse_left  in  1  left button level, synchronous to pclk
- vsync_in  in  1  timing-generator vsync; its rising edge marks a frame boundary
- score_l_pulse  in  1  one-cycle pulse, left player scored
- score_r_pulse  in  1  one-cycle pulse, right player scored
- menu_hsync, menu_vsync  in  1  menu pipeline syncs
- menu_rgb  in  12  menu pipeline colour
- game_hsync, game_vsync  in  1  game pipeline syncs
- game_rgb  in  12  game pipeline colour
- hsync_out, vsync_out  out  1  selected syncs, registered
- rgb_out  out  12  selected colour, registered
- game_rst  out  1  holds ball/paddle logic in reset
- game_run  out  1  enables ball motion
- state_out  out  3  current state encoding
- score_l, score_r  out  4  current scores
- winner  out  2  match result: 00 none, 01 left, 10 right, 11 draw
- countdown_out  out  8  frames remaining in COUNTDOWN, 0 otherwise

Behaviour:
- Reset: synchronous on pclk and overrides everything, including mid-match. Resulting values:
  - state MENU, src_sel 0, scores 0, winner 00, countdown_out 0, frame counter 0
  - hsync_out 0, vsync_out 0, rgb_out 0
  - game_rst 1, game_run 0
- frame_tick: vsync_in is registered; frame_tick is a one-cycle pulse on its 0->1 transition.
- Click edges: mouse_left is registered; press and release are the 0->1 and 1->0 transitions.
- in_btn: BTN_X0 <= xpos < BTN_X0+BTN_W and BTN_Y0 <= ypos < BTN_Y0+BTN_H.
  - Sums are 13-bit unsigned, so there is no wrap-around.
- State transitions:
  - MENU: press with in_btn -> ARMED.
  - ARMED:
    - release with in_btn -> COUNTDOWN; the frame counter loads COUNTDOWN_FRAMES, both scores clear, winner clears.
    - release without in_btn -> MENU.
  - COUNTDOWN: the counter decrements on each frame_tick. When a frame_tick arrives with the counter at 1, the state goes to PLAY and the counter goes to 0. This gives exactly COUNTDOWN_FRAMES ticks.
  - PLAY: see the scoring rules below.
  - OVER: the counter loads OVER_FRAMES on entry and decrements per frame_tick. At 1 -> MENU. Clicks are ignored.
- Scoring (PLAY only):
  - Each score pulse increments its score, saturating at WIN_SCORE.
  - Simultaneous pulses increment both scores in the same cycle.
  - When either score reaches WIN_SCORE -> OVER, with winner 01, 10, or 11 if both reach it in the same cycle.
  - Pulses received outside PLAY are ignored.
- State-driven outputs:
  - game_rst = 1 in MENU and ARMED; 0 in all other states.
  - game_run = 1 only in PLAY.
  - countdown_out shows the counter in COUNTDOWN and 0 in other states.
- Video select:
  - The target source is game in COUNTDOWN, PLAY and OVER, and menu otherwise.
  - src_sel takes the target only on frame_tick, so a frame is never torn.
- Output mux: registered, 1-cycle latency, from the selected pipeline's syncs and rgb to hsync_out, vsync_out and rgb_out.
- State encoding: MENU 0, ARMED 1, COUNTDOWN 2, PLAY 3, OVER 4, PAUSE 5. Unused codes go to MENU.

Optional Feature:
- Macro: GAME_PAUSE_EN.
- Defined:
  - In PLAY, press with in_btn -> PAUSE, with game_run 0 and scores held.
  - In PAUSE, press with in_btn -> PLAY.
  - Score pulses in PAUSE are ignored.
  - The video source stays game.
- Undefined: the PAUSE state is absent and clicks in PLAY are ignored.

Decomposition:
- Shared package pong_pkg holds:
  - state encodings
  - RGB_W = 12 and COORD_W = 12
  - winner codes
- Sub-module edge_detect (registered rising/falling pulse generator) is instantiated for vsync_in and mouse_left.

Test Plan:
- Reset mid-PLAY with score 3:1 -> next cycle: state 0, scores 0, game_rst 1, rgb_out 0.
- Press at (400,290), release at (400,295) -> COUNTDOWN. countdown_out = 180, then reaches PLAY after exactly 180 vsync rising edges. src_sel switches only on the first frame_tick.
- Press at (400,290), release at (10,10) -> ARMED then MENU, scores unchanged. A click at x=480 (edge, exclusive) produces no ARMED.
- In PLAY, 5 score_r_pulse -> score_r = 5, winner 10, OVER. 240 frames later -> MENU, with rgb_out following menu_rgb 1 cycle late from the next frame.
- At 4:4, simultaneous score pulses -> 5:5, winner 11, OVER. A pulse in OVER leaves the scores unchanged.
- With GAME_PAUSE_EN defined: click in PLAY -> state 5, game_run 0, score pulse ignored. A second click -> state 3.
